// File: rtl/div_32_seq_if.sv
// Start/done handshake and operand/result bus for the sequential divider.
// The control sequencer drives through master and the divider sits on slave.
interface div_32_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/div_32_seq.sv
// Multi-cycle signed divider using a radix-2 restoring engine.
// Quotient goes to Z low / LO and remainder goes to Z high / HI; the sequencer stalls until done.
//
// state | meaning
// IDLE  | waiting for start; operand signs and magnitudes are captured on accept
// CALC  | one restoring iteration per clock, WIDTH iterations in total
// FIX   | applies the signs to the results and registers the outputs
// DONE  | done is high for one cycle, then the machine returns to IDLE
module div_32_seq #(
   parameter int WIDTH = 32
) (
   input  logic        Clock,
   input  logic        clear,
   div_32_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH:0]   acc;
   logic [WIDTH-1:0] quo_sr;
   logic [WIDTH-1:0] mag_m;
   logic             sign_q;
   logic             sign_r;
   logic             zero_div;

   logic             busy_r;
   logic             done_r;
   logic             dbz_r;
   logic [WIDTH-1:0] quot_r;
   logic [WIDTH-1:0] rem_r;

   logic [WIDTH-1:0] mag_dividend;
   logic [WIDTH-1:0] mag_divisor;
   logic [WIDTH+1:0] acc_sh;
   logic [WIDTH+1:0] trial;

   // Magnitudes are unsigned, so the most negative operand maps cleanly to 2^(WIDTH-1).
   always_comb begin
      mag_dividend = bus.dividend[WIDTH-1] ? (~bus.dividend + 1'b1) : bus.dividend;
      mag_divisor  = bus.divisor[WIDTH-1]  ? (~bus.divisor + 1'b1)  : bus.divisor;
      acc_sh       = {acc, quo_sr[WIDTH-1]};
      trial        = acc_sh - {2'b00, mag_m};
   end

   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         state    <= IDLE;
         count    <= '0;
         acc      <= '0;
         quo_sr   <= '0;
         mag_m    <= '0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
         zero_div <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         dbz_r    <= 1'b0;
         quot_r   <= '0;
         rem_r    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  sign_q   <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                  sign_r   <= bus.dividend[WIDTH-1];
                  zero_div <= (bus.divisor == '0);
                  quo_sr   <= mag_dividend;
                  mag_m    <= mag_divisor;
                  acc      <= '0;
                  count    <= '0;
                  busy_r   <= 1'b1;
                  state    <= CALC;
               end
            end
            CALC: begin
               // Partial remainder stays below 2*M, so the top bit of trial is a valid sign.
               if (!trial[WIDTH+1]) begin
                  acc    <= trial[WIDTH:0];
                  quo_sr <= {quo_sr[WIDTH-2:0], 1'b1};
               end else begin
                  acc    <= acc_sh[WIDTH:0];
                  quo_sr <= {quo_sr[WIDTH-2:0], 1'b0};
               end
               count <= count + 1'b1;
               if (count == CW'(WIDTH - 1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               // A zero divisor leaves |dividend| in A, so the remainder returns the dividend as-is.
               if (zero_div) begin
                  quot_r <= '1;
               end else begin
                  quot_r <= sign_q ? (~quo_sr + 1'b1) : quo_sr;
               end
               rem_r  <= sign_r ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
               dbz_r  <= zero_div;
               busy_r <= 1'b0;
               done_r <= 1'b1;
               state  <= DONE;
            end
            DONE: begin
               done_r <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.quotient    = quot_r;
   assign bus.remainder   = rem_r;
   assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_div_32_seq.sv
// Bench for div_32_seq: directed corner cases plus random operands checked
// against a plain signed-arithmetic reference model.
module tb_div_32_seq;
   localparam int WIDTH = 32;

   logic Clock = 1'b0;
   logic clear;
   int   checks   = 0;
   int   failures = 0;

   div_32_seq_if #(.WIDTH(WIDTH)) dif ();

   div_32_seq #(.WIDTH(WIDTH)) dut (
      .Clock (Clock),
      .clear (clear),
      .bus   (dif)
   );

   always #5 Clock = ~Clock;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Truncating signed division, with the overflow and zero-divisor cases handled explicitly.
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r,
                                   output logic dz);
      int sa;
      int sb;
      sa = a;
      sb = b;
      dz = 1'b0;
      if (b == 32'h0) begin
         q  = 32'hFFFF_FFFF;
         r  = a;
         dz = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'h0;
      end else begin
         q = sa / sb;
         r = sa % sb;
      end
   endfunction

   // Called at a negedge while the DUT is in IDLE; the next posedge is the accept edge.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int inject_at,
                         input string tag);
      logic [31:0] eq;
      logic [31:0] er;
      logic        edz;
      int          n;
      int          busy_cnt;
      ref_div(a, b, eq, er, edz);
      dif.dividend = a;
      dif.divisor  = b;
      dif.start    = 1'b1;
      @(posedge Clock);
      #1;
      dif.start    = 1'b0;
      dif.dividend = $urandom;
      dif.divisor  = $urandom;
      n        = 0;
      busy_cnt = 0;
      while (n < 100) begin
         @(negedge Clock);
         if (dif.done) break;
         if (dif.busy) busy_cnt++;
         @(posedge Clock);
         n++;
         if (inject_at > 0 && n == inject_at) begin
            #1;
            dif.start    = 1'b1;
            dif.dividend = 32'd50;
            dif.divisor  = 32'd5;
         end else if (inject_at > 0 && n == inject_at + 1) begin
            #1;
            dif.start = 1'b0;
         end
      end
      check_val({tag, " latency"}, 32'(n), 32'd33);
      check_val({tag, " busy_cycles"}, 32'(busy_cnt), 32'd33);
      check_val({tag, " busy_at_done"}, 32'(dif.busy), 32'd0);
      check_val({tag, " quotient"}, dif.quotient, eq);
      check_val({tag, " remainder"}, dif.remainder, er);
      check_val({tag, " div_by_zero"}, 32'(dif.div_by_zero), 32'(edz));
      @(posedge Clock);
      @(negedge Clock);
      check_val({tag, " done_pulse"}, 32'(dif.done), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] bb_a [3];
      logic [31:0] bb_b [3];
      logic [31:0] eq;
      logic [31:0] er;
      logic        edz;
      logic [31:0] ra;
      logic [31:0] rb;
      int          n;
      int          done_seen;

      dif.start    = 1'b0;
      dif.dividend = '0;
      dif.divisor  = '0;
      clear        = 1'b1;
      #2;
      clear = 1'b0;
      #3;
      check_val("rst quotient", dif.quotient, 32'h0);
      check_val("rst remainder", dif.remainder, 32'h0);
      check_val("rst busy", 32'(dif.busy), 32'd0);
      check_val("rst done", 32'(dif.done), 32'd0);
      check_val("rst dbz", 32'(dif.div_by_zero), 32'd0);
      repeat (2) @(negedge Clock);
      clear = 1'b1;
      @(negedge Clock);

      run_op(32'h0000_0012, 32'h0000_0014, 0, "small");
      run_op(32'd100, 32'd7, 0, "100/7");
      run_op(32'hFFFF_FFF9, 32'd2, 0, "-7/2");
      run_op(32'd7, 32'hFFFF_FFFE, 0, "7/-2");
      run_op(32'h1234_5678, 32'h0, 0, "dbz");
      run_op(32'd81, 32'd9, 0, "dbz_clear");
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 0, "overflow");
      run_op(32'h8000_0000, 32'h0, 0, "min_by_zero");
      run_op(32'hFFFF_FF00, 32'h0, 0, "neg_by_zero");
      run_op(32'd100, 32'd7, 10, "ignore_start");

      for (int i = 0; i < 16; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'h0;
            1: rb = 32'($urandom_range(1, 20));
            2: rb = -32'($urandom_range(1, 20));
            3: rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
         run_op(ra, rb, 0, "random");
      end

      // Start held high: back-to-back operations.
      bb_a[0] = 32'd100;        bb_b[0] = 32'd7;
      bb_a[1] = 32'hFFFF_FF9C;  bb_b[1] = 32'd9;
      bb_a[2] = 32'd1000;       bb_b[2] = 32'd3;
      dif.dividend = bb_a[0];
      dif.divisor  = bb_b[0];
      dif.start    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n = 0;
         while (n < 100) begin
            @(posedge Clock);
            n++;
            @(negedge Clock);
            if (dif.done) break;
         end
         ref_div(bb_a[i], bb_b[i], eq, er, edz);
         check_val("b2b spacing", 32'(n), (i == 0) ? 32'd34 : 32'd35);
         check_val("b2b quotient", dif.quotient, eq);
         check_val("b2b remainder", dif.remainder, er);
         if (i < 2) begin
            dif.dividend = bb_a[i+1];
            dif.divisor  = bb_b[i+1];
         end else begin
            dif.start = 1'b0;
         end
      end
      @(posedge Clock);
      @(negedge Clock);

      // Asynchronous reset in the middle of an operation.
      dif.dividend = 32'd100;
      dif.divisor  = 32'd7;
      dif.start    = 1'b1;
      @(posedge Clock);
      #1;
      dif.start = 1'b0;
      repeat (14) @(posedge Clock);
      #2;
      clear = 1'b0;
      #1;
      check_val("abort quotient", dif.quotient, 32'h0);
      check_val("abort remainder", dif.remainder, 32'h0);
      check_val("abort busy", 32'(dif.busy), 32'd0);
      check_val("abort done", 32'(dif.done), 32'd0);
      check_val("abort dbz", 32'(dif.div_by_zero), 32'd0);
      repeat (3) @(negedge Clock);
      clear     = 1'b1;
      done_seen = 0;
      repeat (40) begin
         @(negedge Clock);
         if (dif.done || dif.busy) done_seen++;
      end
      check_val("abort no_done", 32'(done_seen), 32'd0);
      run_op(32'd9, 32'd3, 0, "after_abort");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
